wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage: the writer side of the RF read/write interface. Holds the MEM/WB pipeline
//  register and selects the result (ALU, load or PC+4). Extends load data and drives RF
//  we/w_add/w_data. Exports a forwarding tap and a retired-instruction counter.
//  Registers on posedge clk, so write-port signals are stable before the RF's negedge write.
// PARAMETERS
//  XLEN   32  datapath width (only 32 supported)
//  CNT_W  64  width of retired-instruction counter
// PORTS
//  clk             in   1     clock, posedge
//  rst_n           in   1     synchronous active-low reset
//  stall_wb        in   1     hold MEM/WB register contents
//  flush_wb        in   1     squash: load a bubble into MEM/WB
//  mem_valid       in   1     MEM stage carries a real instruction
//  mem_reg_write   in   1     instruction writes rd
//  mem_rd          in   5     destination register
//  mem_result_src  in   2     00 ALU, 01 load, 10 PC+4, 11 reserved
//  mem_funct3      in   3     load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//  mem_alu_result  in   XLEN  ALU result / load address
//  mem_read_data   in   XLEN  raw aligned word from data memory
//  mem_pc_plus4    in   XLEN  link value
//  rf_we           out  1     RF write enable
//  rf_w_add        out  5     RF write address
//  rf_w_data       out  XLEN  RF write data
//  fwd_valid       out  1     forwarding tap valid (== rf_we)
//  fwd_rd          out  5     forwarding tap register
//  fwd_data        out  XLEN  forwarding tap data (== rf_w_data)
//  illegal_load    out  1     WB holds a load with reserved funct3
//  instret         out  CNT_W retired-instruction count
// BEHAVIOUR
//  - Posedge, priority: !rst_n > flush_wb > stall_wb > capture. Reset clears valid, rd, ctrl,
//    data and instret. All outputs are 0 during and after reset until the first capture.
//  - flush_wb with stall_wb: the flush wins and a bubble is loaded. Reset mid-stall drops the
//    held instruction; it is not counted.
//  - Capture: the MEM/WB register takes all mem_* inputs; valid <= mem_valid. Latency: 1 cycle
//    from MEM inputs to rf_* outputs.
//  - Outputs are combinational from the MEM/WB register only; there is no path from mem_* inputs.
//  - rf_we = wb_valid & wb_reg_write & (wb_rd != 0). x0 writes are suppressed here as well as
//    in the RF.
//  - rf_w_add = wb_rd is always driven. rf_w_data comes from the result_src mux.
//    Reserved src 11 -> data 0.
//  - Load extension uses off = wb_alu_result[1:0]:
//    LB/LBU: byte at off*8, sign/zero-extended. LH/LHU: half at off[1]*16, with off[0] ignored.
//    LW: whole word, off ignored.
//  - Reserved funct3 (011,110,111) on src 01: data 0, illegal_load = 1, and rf_we still follows
//    the rule above.
//  - While stalled, the register holds and rf_we stays asserted. The RF rewrites identical data,
//    which is harmless.
//  - instret += 1 on each cycle with wb_valid & !stall_wb & !flush_wb & rst_n. This counts each
//    instruction exactly once as it leaves WB. Bubbles are not counted.
//    Wraps from all-ones to 0 without a flag.
// STRUCTURE
//  - Shared package/include (rv_defs): RES_SRC_ALU/LOAD/PC4 codes, F3_LB/LH/LW/LBU/LHU codes,
//    and XLEN.
//  - One sub-module, load_ext: combinational (raw word, off, funct3) -> extended data, illegal.
//  - Top level holds the MEM/WB register, result mux, write-port gating and the instret counter.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with mem_valid=1 -> rf_we=0, rf_w_data=0, instret=0.
//  2. ALU write: rd=5, src=00, alu=0x12345678 -> next cycle rf_we=1, w_add=5,
//     w_data=0x12345678, instret=1.
//  3. Loads from word 0x80FF7F01:
//     - LB off=1 -> 0x0000007F
//     - LB off=2 -> 0xFFFFFFFF
//     - LBU off=3 -> 0x00000080
//     - LH off=2 -> 0xFFFF80FF
//     - LHU off=0 -> 0x00007F01
//  4. x0/illegal: rd=0 ALU write -> rf_we=0. funct3=011 load rd=3 -> w_data=0,
//     illegal_load=1, rf_we=1.
//  5. Stall 3 cycles then release -> outputs held for all 3, and instret increments once only.
//     Flush together with stall -> bubble, rf_we=0, no count.
//  6. JAL link: rd=1, src=10, pc4=0x00000104 -> w_data=0x104. Preload instret near all-ones
//     via 2^CNT_W-1 retires (small CNT_W=4 instance) -> wraps to 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: result-select and load-type codes,
// datapath width and the MEM/WB pipeline register layout.
package wb_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RES_SRC_ALU  = 2'b00;
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;
    localparam logic [1:0] RES_SRC_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [1:0]      result_src;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus4;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB inputs, RF write port, forwarding tap and status of the writeback stage.
// The master side is whatever feeds the stage; the slave side is wb_stage itself.
interface wb_stage_if #(parameter int CNT_W = 64);

    logic                          stall_wb;
    logic                          flush_wb;
    logic                          mem_valid;
    logic                          mem_reg_write;
    logic [4:0]                    mem_rd;
    logic [1:0]                    mem_result_src;
    logic [2:0]                    mem_funct3;
    logic [wb_stage_pkg::XLEN-1:0] mem_alu_result;
    logic [wb_stage_pkg::XLEN-1:0] mem_read_data;
    logic [wb_stage_pkg::XLEN-1:0] mem_pc_plus4;

    logic                          rf_we;
    logic [4:0]                    rf_w_add;
    logic [wb_stage_pkg::XLEN-1:0] rf_w_data;
    logic                          fwd_valid;
    logic [4:0]                    fwd_rd;
    logic [wb_stage_pkg::XLEN-1:0] fwd_data;
    logic                          illegal_load;
    logic [CNT_W-1:0]              instret;

    modport master (
        output stall_wb, flush_wb, mem_valid, mem_reg_write, mem_rd, mem_result_src,
               mem_funct3, mem_alu_result, mem_read_data, mem_pc_plus4,
        input  rf_we, rf_w_add, rf_w_data, fwd_valid, fwd_rd, fwd_data, illegal_load, instret
    );

    modport slave (
        input  stall_wb, flush_wb, mem_valid, mem_reg_write, mem_rd, mem_result_src,
               mem_funct3, mem_alu_result, mem_read_data, mem_pc_plus4,
        output rf_we, rf_w_add, rf_w_data, fwd_valid, fwd_rd, fwd_data, illegal_load, instret
    );

endinterface

// File: rtl/wb_stage_load_ext.sv
// Load data extension: picks the byte/half out of the aligned memory word and
// sign- or zero-extends it. Reserved load types yield zero and raise illegal.
module wb_stage_load_ext
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection; the low offset bit is irrelevant for halfwords.
    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = off[1] ? raw[31:16] : raw[15:0];
    end

    // Extension by load type.
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = raw;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result mux, RF write-port gating,
// forwarding tap and retired-instruction counter. Outputs depend only on the
// registered state so they settle well before the RF's negedge write.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    wb_stage_if.slave bus
);

    mem_wb_t          wb_q;
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  load_data;
    logic             load_illegal;
    logic [XLEN-1:0]  result;
    logic             we;

    // MEM/WB register: reset > flush (bubble) > stall (hold) > capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else if (bus.flush_wb) begin
            wb_q <= '0;
        end else if (!bus.stall_wb) begin
            wb_q <= '{valid:      bus.mem_valid,
                      reg_write:  bus.mem_reg_write,
                      rd:         bus.mem_rd,
                      result_src: bus.mem_result_src,
                      funct3:     bus.mem_funct3,
                      alu_result: bus.mem_alu_result,
                      read_data:  bus.mem_read_data,
                      pc_plus4:   bus.mem_pc_plus4};
        end
    end

    // Count an instruction once, on the cycle it actually leaves WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (wb_q.valid && !bus.stall_wb && !bus.flush_wb) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    wb_stage_load_ext u_load_ext (
        .raw     (wb_q.read_data),
        .off     (wb_q.alu_result[1:0]),
        .funct3  (wb_q.funct3),
        .data    (load_data),
        .illegal (load_illegal)
    );

    // Result select; the reserved source code writes zero.
    always_comb begin
        result = '0;
        case (wb_q.result_src)
            RES_SRC_ALU:  result = wb_q.alu_result;
            RES_SRC_LOAD: result = load_data;
            RES_SRC_PC4:  result = wb_q.pc_plus4;
            default:      result = '0;
        endcase
    end

    // Write-port gating: x0 is never written, even if the RF would also drop it.
    always_comb begin
        we = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);
    end

    assign bus.rf_we        = we;
    assign bus.rf_w_add     = wb_q.rd;
    assign bus.rf_w_data    = result;
    assign bus.fwd_valid    = we;
    assign bus.fwd_rd       = wb_q.rd;
    assign bus.fwd_data     = result;
    assign bus.illegal_load = wb_q.valid & (wb_q.result_src == RES_SRC_LOAD) & load_illegal;
    assign bus.instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps followed by random traffic, all checked
// against a behavioural model of the writeback rules. A CNT_W=4 copy runs on
// the same stimulus to exercise counter wrap.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_stage_if #(.CNT_W(64)) bus64 ();
    wb_stage_if #(.CNT_W(4))  bus4 ();

    assign bus4.stall_wb       = bus64.stall_wb;
    assign bus4.flush_wb       = bus64.flush_wb;
    assign bus4.mem_valid      = bus64.mem_valid;
    assign bus4.mem_reg_write  = bus64.mem_reg_write;
    assign bus4.mem_rd         = bus64.mem_rd;
    assign bus4.mem_result_src = bus64.mem_result_src;
    assign bus4.mem_funct3     = bus64.mem_funct3;
    assign bus4.mem_alu_result = bus64.mem_alu_result;
    assign bus4.mem_read_data  = bus64.mem_read_data;
    assign bus4.mem_pc_plus4   = bus64.mem_pc_plus4;

    wb_stage #(.CNT_W(64)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus64));
    wb_stage #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int errors = 0;
    int checks = 0;

    // Model of the instruction currently sitting in WB, and of the retire count.
    bit          m_valid, m_regw;
    int unsigned m_rd, m_src, m_f3;
    int unsigned m_alu, m_rdata, m_pc4;
    longint unsigned m_cnt;

    function automatic int unsigned ref_data(int unsigned src, int unsigned f3,
                                             int unsigned alu, int unsigned w, int unsigned pc4);
        int unsigned off, b, h;
        off = alu % 4;
        b   = (w >> (8 * off)) & 32'hFF;
        h   = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (src == 0) return alu;
        if (src == 2) return pc4;
        if (src == 3) return 0;
        case (f3)
            0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4: return b;
            1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            5: return h;
            2: return w;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          e_we, e_ill;
        int unsigned e_data;
        e_we   = m_valid && m_regw && (m_rd != 0);
        e_data = ref_data(m_src, m_f3, m_alu, m_rdata, m_pc4);
        e_ill  = m_valid && (m_src == 1) && (m_f3 == 3 || m_f3 == 6 || m_f3 == 7);
        chk("rf_we",        64'(bus64.rf_we),        64'(e_we));
        chk("rf_w_add",     64'(bus64.rf_w_add),     64'(m_rd));
        chk("rf_w_data",    64'(bus64.rf_w_data),    64'(e_data));
        chk("fwd_valid",    64'(bus64.fwd_valid),    64'(e_we));
        chk("fwd_rd",       64'(bus64.fwd_rd),       64'(m_rd));
        chk("fwd_data",     64'(bus64.fwd_data),     64'(e_data));
        chk("illegal_load", 64'(bus64.illegal_load), 64'(e_ill));
        chk("instret",      bus64.instret,           m_cnt);
        chk("instret4",     64'(bus4.instret),       m_cnt % 16);
        chk("dut4_w_data",  64'(bus4.rf_w_data),     64'(e_data));
    endtask

    // Apply one clock edge to the model using the inputs currently driven, then
    // let the DUTs take the same edge and compare.
    task automatic tick();
        if (!rst_n) begin
            m_valid = 0; m_regw = 0; m_rd = 0; m_src = 0; m_f3 = 0;
            m_alu = 0; m_rdata = 0; m_pc4 = 0; m_cnt = 0;
        end else if (bus64.flush_wb) begin
            m_valid = 0; m_regw = 0; m_rd = 0; m_src = 0; m_f3 = 0;
            m_alu = 0; m_rdata = 0; m_pc4 = 0;
        end else if (!bus64.stall_wb) begin
            if (m_valid) m_cnt++;
            m_valid = bus64.mem_valid;
            m_regw  = bus64.mem_reg_write;
            m_rd    = bus64.mem_rd;
            m_src   = bus64.mem_result_src;
            m_f3    = bus64.mem_funct3;
            m_alu   = bus64.mem_alu_result;
            m_rdata = bus64.mem_read_data;
            m_pc4   = bus64.mem_pc_plus4;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc4);
        bus64.mem_valid      = v;
        bus64.mem_reg_write  = rw;
        bus64.mem_rd         = rd;
        bus64.mem_result_src = src;
        bus64.mem_funct3     = f3;
        bus64.mem_alu_result = alu;
        bus64.mem_read_data  = rdat;
        bus64.mem_pc_plus4   = pc4;
    endtask

    longint unsigned c0;

    initial begin
        rst_n = 1'b0;
        bus64.stall_wb = 1'b0;
        bus64.flush_wb = 1'b0;
        drive(1, 1, 5'd9, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
        m_cnt = 0;

        // Reset with a valid instruction presented.
        tick();
        tick();
        chk("rst_rf_we", 64'(bus64.rf_we), 64'd0);
        chk("rst_w_data", 64'(bus64.rf_w_data), 64'd0);
        chk("rst_instret", bus64.instret, 64'd0);

        // ALU write to x5.
        rst_n = 1'b1;
        drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
        tick();
        chk("alu_we", 64'(bus64.rf_we), 64'd1);
        chk("alu_add", 64'(bus64.rf_w_add), 64'd5);
        chk("alu_data", 64'(bus64.rf_w_data), 64'h1234_5678);

        // Loads from 0x80FF7F01.
        drive(1, 1, 5'd6, 2'b01, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        tick();
        chk("alu_retired", bus64.instret, 64'd1);
        chk("lb_off1", 64'(bus64.rf_w_data), 64'h0000_007F);
        drive(1, 1, 5'd6, 2'b01, 3'b000, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        tick();
        chk("lb_off2", 64'(bus64.rf_w_data), 64'hFFFF_FFFF);
        drive(1, 1, 5'd6, 2'b01, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        tick();
        chk("lbu_off3", 64'(bus64.rf_w_data), 64'h0000_0080);
        drive(1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        tick();
        chk("lh_off2", 64'(bus64.rf_w_data), 64'hFFFF_80FF);
        drive(1, 1, 5'd6, 2'b01, 3'b101, 32'h0000_1000, 32'h80FF_7F01, 32'h0);
        tick();
        chk("lhu_off0", 64'(bus64.rf_w_data), 64'h0000_7F01);

        // x0 suppression and reserved load type.
        drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h5555_AAAA, 32'h0, 32'h0);
        tick();
        chk("x0_we", 64'(bus64.rf_we), 64'd0);
        drive(1, 1, 5'd3, 2'b01, 3'b011, 32'h0000_2000, 32'h80FF_7F01, 32'h0);
        tick();
        chk("ill_data", 64'(bus64.rf_w_data), 64'd0);
        chk("ill_flag", 64'(bus64.illegal_load), 64'd1);
        chk("ill_we", 64'(bus64.rf_we), 64'd1);

        // Stall for three cycles, then release.
        drive(1, 1, 5'd7, 2'b00, 3'b000, 32'h0000_CAFE, 32'h0, 32'h0);
        tick();
        c0 = bus64.instret;
        bus64.stall_wb = 1'b1;
        drive(1, 1, 5'd8, 2'b00, 3'b000, 32'h1111_2222, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", 64'(bus64.rf_w_data), 64'h0000_CAFE);
            chk("stall_we", 64'(bus64.rf_we), 64'd1);
            chk("stall_cnt", bus64.instret, c0);
        end
        bus64.stall_wb = 1'b0;
        tick();
        chk("release_cnt", bus64.instret, c0 + 1);

        // Flush together with stall loads a bubble and counts nothing.
        bus64.stall_wb = 1'b1;
        bus64.flush_wb = 1'b1;
        tick();
        chk("flush_we", 64'(bus64.rf_we), 64'd0);
        chk("flush_cnt", bus64.instret, c0 + 1);
        bus64.stall_wb = 1'b0;
        bus64.flush_wb = 1'b0;

        // JAL link value.
        drive(1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0F00, 32'h0, 32'h0000_0104);
        tick();
        chk("bubble_cnt", bus64.instret, c0 + 1);
        chk("jal_data", 64'(bus64.rf_w_data), 64'h0000_0104);

        // Counter wrap on the 4-bit instance: 16 retirements after reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i), 32'h0, 32'h0);
            tick();
        end
        chk("wrap_cnt4", 64'(bus4.instret), 64'd0);
        chk("wrap_cnt64", bus64.instret, 64'd16);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 49) != 0);
            bus64.stall_wb = ($urandom_range(0, 4) == 0);
            bus64.flush_wb = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
